// File: rtl/treasury_nonce_dispatcher_pkg.sv
// Shared types and helpers for the treasury nonce dispatcher.
// Holds the FSM state enum, width defaults and the lane priority picker.
package treasury_pkg;

    localparam int NONCE_W_DEFAULT = 32;
    localparam int MAX_LANES       = 64;
    localparam int LANE_IDX_W      = 6;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Lowest-index lane wins when several lanes report a hit together.
    function automatic logic [LANE_IDX_W-1:0] lowest_set(input logic [MAX_LANES-1:0] vec);
        logic [LANE_IDX_W-1:0] idx;
        idx = '0;
        for (int i = MAX_LANES - 1; i >= 0; i--) begin
            if (vec[i]) idx = LANE_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/treasury_nonce_dispatcher_if.sv
// Job, lane and result signals of the nonce dispatcher grouped as one bus.
// The dispatcher connects through the slave modport; its environment uses master.
interface treasury_nonce_dispatcher_if #(
    parameter int LANES   = 27,
    parameter int NONCE_W = treasury_pkg::NONCE_W_DEFAULT,
    parameter int CNT_W   = 48
);
    logic                     job_valid;
    logic                     job_ready;
    logic [NONCE_W-1:0]       job_base;
    logic [NONCE_W-1:0]       job_limit;
    logic                     abort;
    logic [LANES-1:0]         lane_start;
    logic [LANES*NONCE_W-1:0] lane_nonce;
    logic [LANES-1:0]         lane_done;
    logic [LANES-1:0]         lane_hit;
    logic                     result_valid;
    logic                     result_ready;
    logic                     result_found;
    logic                     result_exhausted;
    logic [NONCE_W-1:0]       result_nonce;
    logic [CNT_W-1:0]         hash_count;

    modport master (
        output job_valid, job_base, job_limit, abort, lane_done, lane_hit, result_ready,
        input  job_ready, lane_start, lane_nonce, result_valid, result_found,
               result_exhausted, result_nonce, hash_count
    );

    modport slave (
        input  job_valid, job_base, job_limit, abort, lane_done, lane_hit, result_ready,
        output job_ready, lane_start, lane_nonce, result_valid, result_found,
               result_exhausted, result_nonce, hash_count
    );

endinterface

// File: rtl/treasury_nonce_dispatcher_slot.sv
// One hasher lane: strided nonce counter, busy flag and the nonce last issued.
// The counter is one bit wider than a nonce so a range ending at all-ones stops cleanly.
module treasury_lane_slot #(
    parameter int NONCE_W = 32,
    parameter int STRIDE  = 27
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [NONCE_W:0]   first,
    input  logic [NONCE_W-1:0] limit,
    input  logic               issue_en,
    input  logic               done,
    output logic               start,
    output logic               busy,
    output logic               pending,
    output logic               accepted,
    output logic [NONCE_W-1:0] nonce,
    output logic [NONCE_W-1:0] issued
);
    localparam logic [NONCE_W:0] STEP = (NONCE_W + 1)'(STRIDE);

    logic [NONCE_W:0] next_nonce;

    assign pending  = next_nonce <= {1'b0, limit};
    assign start    = issue_en && !busy && pending;
    assign accepted = done && busy;
    assign nonce    = next_nonce[NONCE_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            next_nonce <= '0;
            busy       <= 1'b0;
            issued     <= '0;
        end else if (load) begin
            next_nonce <= first;
            busy       <= 1'b0;
        end else if (start) begin
            busy       <= 1'b1;
            issued     <= nonce;
            next_nonce <= next_nonce + STEP;
        end else if (accepted) begin
            busy       <= 1'b0;
        end
    end

endmodule

// File: rtl/treasury_nonce_dispatcher.sv
// Nonce-search controller: spreads a job range over LANES hashers with a stride of LANES
// and reports the first hit, exhaustion or abort together with the completed-hash count.
module treasury_nonce_dispatcher
    import treasury_pkg::*;
#(
    parameter int LANES   = 27,
    parameter int NONCE_W = NONCE_W_DEFAULT,
    parameter int CNT_W   = 48
) (
    input  logic clk,
    input  logic rst,
    treasury_nonce_dispatcher_if.slave bus
);
    state_t state, state_nx;

    logic                     accept;
    logic                     hit_any;
    logic                     exhaust_now;
    logic [LANES-1:0]         start;
    logic [LANES-1:0]         busy;
    logic [LANES-1:0]         pending;
    logic [LANES-1:0]         accepted;
    logic [LANES-1:0]         hits;
    logic [NONCE_W-1:0]       nonce  [LANES];
    logic [NONCE_W-1:0]       issued [LANES];
    logic [MAX_LANES-1:0]     hit_wide;
    logic [LANE_IDX_W-1:0]    hit_idx;
    logic [NONCE_W-1:0]       hit_nonce;
    logic [LANES*NONCE_W-1:0] nonce_bus;
    logic [CNT_W:0]           count_sum;
    logic [CNT_W-1:0]         count_nx;
    logic [NONCE_W-1:0]       limit_q;
    logic                     found_q;
    logic                     exhausted_q;
    logic [NONCE_W-1:0]       nonce_q;
    logic [CNT_W-1:0]         count_q;

    assign accept = (state == IDLE) && bus.job_valid;
    assign hits   = accepted & bus.lane_hit;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam logic [NONCE_W:0] OFFSET = (NONCE_W + 1)'(i);

        treasury_lane_slot #(
            .NONCE_W (NONCE_W),
            .STRIDE  (LANES)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load     (accept),
            .first    ({1'b0, bus.job_base} + OFFSET),
            .limit    (limit_q),
            .issue_en (state == RUN),
            .done     (bus.lane_done[i]),
            .start    (start[i]),
            .busy     (busy[i]),
            .pending  (pending[i]),
            .accepted (accepted[i]),
            .nonce    (nonce[i]),
            .issued   (issued[i])
        );
    end

    always_comb begin
        hit_wide              = '0;
        hit_wide[LANES-1:0]   = hits;
        hit_idx               = lowest_set(hit_wide);
        hit_nonce             = '0;
        for (int i = 0; i < LANES; i++) begin
            if (LANE_IDX_W'(i) == hit_idx) hit_nonce = issued[i];
        end
        hit_any     = (state == RUN) && (|hits);
        exhaust_now = (state == RUN) && !hit_any && !bus.abort && (pending == '0) && (busy == '0);
    end

    // Every accepted lane_done adds one; the counter sticks at all-ones.
    always_comb begin
        count_sum = {1'b0, count_q};
        for (int i = 0; i < LANES; i++) begin
            count_sum = count_sum + {{CNT_W{1'b0}}, accepted[i]};
        end
        count_nx = count_sum[CNT_W] ? '1 : count_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.job_valid) state_nx = (bus.job_limit < bus.job_base) ? DONE : RUN;
            RUN:     if (hit_any || bus.abort) state_nx = DRAIN;
                     else if (exhaust_now)     state_nx = DONE;
            DRAIN:   if (busy == '0) state_nx = DONE;
            DONE:    if (bus.result_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            limit_q     <= '0;
            found_q     <= 1'b0;
            exhausted_q <= 1'b0;
            nonce_q     <= '0;
            count_q     <= '0;
        end else if (accept) begin
            limit_q     <= bus.job_limit;
            found_q     <= 1'b0;
            exhausted_q <= bus.job_limit < bus.job_base;
            nonce_q     <= '0;
            count_q     <= '0;
        end else begin
            count_q <= count_nx;
            if (hit_any) begin
                found_q <= 1'b1;
                nonce_q <= hit_nonce;
            end
            if (exhaust_now) exhausted_q <= 1'b1;
        end
    end

    always_comb begin
        nonce_bus = '0;
        for (int i = 0; i < LANES; i++) begin
            nonce_bus[i*NONCE_W +: NONCE_W] = nonce[i];
        end
    end

    // Outputs are forced low while reset is held, even though state clears one edge later.
    assign bus.job_ready        = !rst && (state == IDLE);
    assign bus.lane_start       = rst ? '0 : start;
    assign bus.lane_nonce       = rst ? '0 : nonce_bus;
    assign bus.result_valid     = !rst && (state == DONE);
    assign bus.result_found     = !rst && found_q;
    assign bus.result_exhausted = !rst && exhausted_q;
    assign bus.result_nonce     = rst ? '0 : nonce_q;
    assign bus.hash_count       = rst ? '0 : count_q;

endmodule

// File: tb/tb_treasury_nonce_dispatcher.sv
// Self-checking bench for treasury_nonce_dispatcher with three lanes and scripted hasher responses.
// A queue-based reference model is compared every cycle; literal totals pin each scenario.
module tb_treasury_nonce_dispatcher;
    localparam int LANES   = 3;
    localparam int NONCE_W = 32;
    localparam int CNT_W   = 48;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    treasury_nonce_dispatcher_if #(.LANES(LANES), .NONCE_W(NONCE_W), .CNT_W(CNT_W)) bus ();

    treasury_nonce_dispatcher #(.LANES(LANES), .NONCE_W(NONCE_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int starts_seen = 0;
    int lat [LANES];
    logic [31:0] hit_list [$];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic bit is_hit(input logic [31:0] n);
        foreach (hit_list[k]) if (hit_list[k] == n) return 1'b1;
        return 1'b0;
    endfunction

    // Scripted hashers: each lane answers lat[i] cycles after its start pulse.
    int          rem [LANES];
    logic [31:0] tag [LANES];

    initial begin
        bus.lane_done = '0;
        bus.lane_hit  = '0;
        for (int i = 0; i < LANES; i++) begin
            rem[i] = 0;
            tag[i] = '0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < LANES; i++) begin
                bus.lane_done[i] = 1'b0;
                bus.lane_hit[i]  = 1'b0;
                if (rem[i] > 0) begin
                    rem[i]--;
                    if (rem[i] == 0) begin
                        bus.lane_done[i] = 1'b1;
                        bus.lane_hit[i]  = is_hit(tag[i]);
                    end
                end
            end
            @(negedge clk);
            for (int i = 0; i < LANES; i++) begin
                if (bus.lane_start[i]) begin
                    rem[i] = lat[i];
                    tag[i] = bus.lane_nonce[i*NONCE_W +: NONCE_W];
                end
            end
        end
    end

    // Reference model: per-lane queues of nonces still owed, lanes in flight, and the job phase.
    localparam int PH_IDLE  = 0;
    localparam int PH_RUN   = 1;
    localparam int PH_DRAIN = 2;
    localparam int PH_DONE  = 3;

    int          phase = PH_IDLE;
    logic [31:0] exp_q [LANES][$];
    bit          in_flight [LANES];
    logic [31:0] owned [LANES];
    longint      done_count = 0;
    bit          found_m = 1'b0;
    bit          exh_m = 1'b0;
    logic [31:0] nonce_m = '0;

    always @(negedge clk) begin
        logic [LANES-1:0] exp_start;
        bit               any_owed;
        bit               any_flight;
        int               hit_lane;
        if (rst) begin
            checkOutput("reset_job_ready", bus.job_ready, 0);
            checkOutput("reset_lane_start", bus.lane_start, 0);
            checkOutput("reset_lane_nonce", 64'(|bus.lane_nonce), 0);
            checkOutput("reset_result_valid", bus.result_valid, 0);
            checkOutput("reset_result_fields", 64'(|{bus.result_found, bus.result_exhausted, bus.result_nonce}), 0);
            checkOutput("reset_hash_count", bus.hash_count, 0);
            phase = PH_IDLE;
            for (int i = 0; i < LANES; i++) begin
                exp_q[i].delete();
                in_flight[i] = 1'b0;
                owned[i] = '0;
            end
            done_count = 0;
            found_m = 1'b0;
            exh_m = 1'b0;
            nonce_m = '0;
        end else begin
            starts_seen += $countones(bus.lane_start);
            exp_start  = '0;
            any_owed   = 1'b0;
            any_flight = 1'b0;
            for (int i = 0; i < LANES; i++) begin
                if (exp_q[i].size() > 0) any_owed = 1'b1;
                if (in_flight[i]) any_flight = 1'b1;
                if (phase == PH_RUN && !in_flight[i] && exp_q[i].size() > 0) exp_start[i] = 1'b1;
            end
            checkOutput("lane_start", bus.lane_start, exp_start);
            for (int i = 0; i < LANES; i++) begin
                if (exp_start[i] && bus.lane_start[i])
                    checkOutput("lane_nonce", bus.lane_nonce[i*NONCE_W +: NONCE_W], exp_q[i][0]);
            end
            checkOutput("job_ready", bus.job_ready, phase == PH_IDLE);
            checkOutput("result_valid", bus.result_valid, phase == PH_DONE);
            checkOutput("hash_count", bus.hash_count, done_count);
            if (phase == PH_DONE) begin
                checkOutput("result_found", bus.result_found, found_m);
                checkOutput("result_exhausted", bus.result_exhausted, exh_m);
                checkOutput("result_nonce", bus.result_nonce, nonce_m);
            end

            hit_lane = -1;
            for (int i = 0; i < LANES; i++) begin
                if (bus.lane_done[i] && in_flight[i]) begin
                    if (phase == PH_RUN && bus.lane_hit[i] && hit_lane < 0) hit_lane = i;
                    in_flight[i] = 1'b0;
                    done_count++;
                end
            end
            if (hit_lane >= 0) nonce_m = owned[hit_lane];
            for (int i = 0; i < LANES; i++) begin
                if (exp_start[i]) begin
                    in_flight[i] = 1'b1;
                    owned[i] = exp_q[i].pop_front();
                end
            end

            case (phase)
                PH_IDLE: if (bus.job_valid) begin
                    done_count = 0;
                    found_m = 1'b0;
                    nonce_m = '0;
                    exh_m = bus.job_limit < bus.job_base;
                    for (int i = 0; i < LANES; i++) begin
                        for (longint n = longint'(bus.job_base) + i; n <= longint'(bus.job_limit); n += LANES)
                            exp_q[i].push_back(n[31:0]);
                    end
                    phase = exh_m ? PH_DONE : PH_RUN;
                end
                PH_RUN: begin
                    if (hit_lane >= 0) begin
                        found_m = 1'b1;
                        phase = PH_DRAIN;
                    end else if (bus.abort) begin
                        phase = PH_DRAIN;
                        for (int i = 0; i < LANES; i++) exp_q[i].delete();
                    end else if (!any_owed && !any_flight) begin
                        exh_m = 1'b1;
                        phase = PH_DONE;
                    end
                    if (phase == PH_DRAIN) for (int i = 0; i < LANES; i++) exp_q[i].delete();
                end
                PH_DRAIN: if (!any_flight) phase = PH_DONE;
                PH_DONE:  if (bus.result_ready) phase = PH_IDLE;
                default:  phase = PH_IDLE;
            endcase
        end
    end

    task automatic applyStimulus(input logic [31:0] base, input logic [31:0] limit);
        @(posedge clk);
        #1;
        bus.job_valid = 1'b1;
        bus.job_base  = base;
        bus.job_limit = limit;
        @(posedge clk);
        #1;
        bus.job_valid = 1'b0;
    endtask

    task automatic waitResult(input string name, output int cycles);
        bit ok;
        ok = 1'b0;
        cycles = 0;
        while (!ok && cycles < 300) begin
            @(negedge clk);
            if (bus.result_valid) ok = 1'b1;
            else cycles++;
        end
        checkOutput({name, "_result_arrived"}, ok, 1);
    endtask

    task automatic releaseResult();
        @(posedge clk);
        #1;
        bus.result_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.result_ready = 1'b0;
    endtask

    task automatic runJob(input string name, input logic [31:0] base, input logic [31:0] limit,
                          input int exp_starts, input bit exp_found, input bit exp_exh,
                          input logic [31:0] exp_nonce, input int exp_count);
        int s0;
        int cycles;
        s0 = starts_seen;
        applyStimulus(base, limit);
        waitResult(name, cycles);
        checkOutput({name, "_starts"}, starts_seen - s0, exp_starts);
        checkOutput({name, "_found"}, bus.result_found, exp_found);
        checkOutput({name, "_exhausted"}, bus.result_exhausted, exp_exh);
        checkOutput({name, "_nonce"}, bus.result_nonce, exp_nonce);
        checkOutput({name, "_hash_count"}, bus.hash_count, exp_count);
        if (exp_starts == 0) checkOutput({name, "_done_latency"}, cycles, 0);
        releaseResult();
    endtask

    initial begin
        int s0;
        bus.job_valid    = 1'b0;
        bus.job_base     = '0;
        bus.job_limit    = '0;
        bus.abort        = 1'b0;
        bus.result_ready = 1'b0;
        for (int i = 0; i < LANES; i++) lat[i] = 2;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] exhaustive range 0..8");
        runJob("t1", 32'd0, 32'd8, 9, 1'b0, 1'b1, 32'd0, 9);

        $display("[TB] hit on nonce 4 while lane 2 is busy");
        lat[2] = 4;
        hit_list.push_back(32'd4);
        runJob("t2", 32'd0, 32'd8, 6, 1'b1, 1'b0, 32'd4, 6);

        $display("[TB] simultaneous hits on nonces 3 and 5");
        lat[2] = 2;
        hit_list.delete();
        hit_list.push_back(32'd3);
        hit_list.push_back(32'd5);
        runJob("t3", 32'd0, 32'd8, 6, 1'b1, 1'b0, 32'd3, 6);
        hit_list.delete();

        $display("[TB] range ending at all-ones");
        runJob("t4", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 2, 1'b0, 1'b1, 32'd0, 2);

        $display("[TB] empty range");
        runJob("t5", 32'd10, 32'd5, 0, 1'b0, 1'b1, 32'd0, 0);

        $display("[TB] abort then reset during drain");
        for (int i = 0; i < LANES; i++) lat[i] = 5;
        applyStimulus(32'd0, 32'd100);
        @(posedge clk);
        #1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        s0 = starts_seen;
        @(negedge clk);
        checkOutput("t6_job_ready_after_rst", bus.job_ready, 1);
        repeat (10) @(negedge clk);
        checkOutput("t6_stale_hash_count", bus.hash_count, 0);
        checkOutput("t6_no_result", bus.result_valid, 0);
        checkOutput("t6_no_starts", starts_seen - s0, 0);

        $display("[TB] recovery job after reset");
        for (int i = 0; i < LANES; i++) lat[i] = 2;
        runJob("t7", 32'd20, 32'd22, 3, 1'b0, 1'b1, 32'd0, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

endmodule
